// File: rtl/des_key_sched.sv
// DES / 3DES key schedule: PC-1 on key accept, then streams 16*NKEYS PC-2 round
// subkeys in cipher order (EDE for three keys) over a valid/ready handshake.
module des_key_sched #(
  parameter int NKEYS      = 1,
  parameter int PARITY_CHK = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [64*NKEYS:1]   key_in,
  input  logic                key_valid,
  output logic                key_ready,
  input  logic                decrypt,
  output logic [48:1]         subkey,
  output logic [5:0]          subkey_idx,
  output logic                subkey_last,
  output logic                subkey_valid,
  input  logic                subkey_ready,
  output logic                parity_err
);

  localparam int KW = 64 * NKEYS;
  localparam logic [1:0] SEG_LAST = 2'(NKEYS - 1);

  localparam int PC1_T [1:56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_T [1:48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  typedef enum logic {IDLE, GEN} state_t;

  state_t      state, state_nxt;
  logic [KW:1] key_q;
  logic        dec_q;
  logic [1:0]  seg;
  logic [3:0]  rnd;
  logic [28:1] c_q, d_q;
  logic        perr_now;
  logic        dir_cur;
  logic        one_step;

  function automatic logic [56:1] pc1(input logic [64:1] k);
    logic [56:1] r;
    for (int i = 1; i <= 56; i++) r[i] = k[PC1_T[i]];
    return r;
  endfunction

  function automatic logic [48:1] pc2(input logic [56:1] cd);
    logic [48:1] r;
    for (int i = 1; i <= 48; i++) r[i] = cd[PC2_T[i]];
    return r;
  endfunction

  // Index n holds FIPS bit n, so a FIPS left rotate moves bits toward index 1.
  function automatic logic [28:1] rot(input logic [28:1] x, input logic right, input logic two);
    if (right) return two ? {x[26:1], x[28:27]} : {x[27:1], x[28]};
    return two ? {x[2:1], x[28:3]} : {x[1], x[28:2]};
  endfunction

  // Stream position s -> key number: EDE runs K1,K2,K3; its inverse runs K3,K2,K1.
  function automatic logic [64:1] seg_key(input logic [KW:1] k, input logic dec, input logic [1:0] s);
    int j;
    if (NKEYS == 1) j = 1;
    else            j = dec ? 3 - int'(s) : int'(s) + 1;
    return k[64*(NKEYS-j)+1 +: 64];
  endfunction

  function automatic logic seg_dir_d(input logic dec, input logic [1:0] s);
    if (NKEYS == 1) return dec;
    return dec ^ (s == 2'd1);
  endfunction

  // Decrypt segments start from the unshifted PC-1 value, which equals C16/D16.
  function automatic logic [56:1] seg_load(input logic [64:1] k, input logic dir_d);
    logic [56:1] cd;
    cd = pc1(k);
    if (dir_d) return cd;
    return {rot(cd[56:29], 1'b0, 1'b0), rot(cd[28:1], 1'b0, 1'b0)};
  endfunction

  always_comb begin
    perr_now = 1'b0;
    if (PARITY_CHK != 0)
      for (int b = 0; b < 8*NKEYS; b++)
        if (!(^key_in[8*b+1 +: 8])) perr_now = 1'b1;
  end

  assign key_ready    = (state == IDLE);
  assign subkey_valid = (state == GEN);
  assign subkey_idx   = {seg, rnd};
  assign subkey_last  = (state == GEN) && (seg == SEG_LAST) && (rnd == 4'd15);
  assign subkey       = pc2({d_q, c_q});
  assign dir_cur      = seg_dir_d(dec_q, seg);
  // Rounds 2, 9 and 16 move by one position, all others by two.
  assign one_step     = (rnd == 4'd0) || (rnd == 4'd7) || (rnd == 4'd14);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (key_valid && !perr_now) state_nxt = GEN;
      GEN:     if (subkey_ready && subkey_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && key_valid && !perr_now) begin
      key_q <= key_in;
      dec_q <= decrypt;
    end
  end

  // Stage boundary: C/D and round position registers feeding the PC-2 output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg        <= 2'd0;
      rnd        <= 4'd0;
      c_q        <= '0;
      d_q        <= '0;
      parity_err <= 1'b0;
    end else if (state == IDLE) begin
      if (key_valid) begin
        parity_err <= perr_now;
        if (!perr_now) begin
          seg        <= 2'd0;
          rnd        <= 4'd0;
          {d_q, c_q} <= seg_load(seg_key(key_in, decrypt, 2'd0), seg_dir_d(decrypt, 2'd0));
        end
      end
    end else if (subkey_ready && !subkey_last) begin
      if (rnd == 4'd15) begin
        seg        <= seg + 2'd1;
        rnd        <= 4'd0;
        {d_q, c_q} <= seg_load(seg_key(key_q, dec_q, seg + 2'd1), seg_dir_d(dec_q, seg + 2'd1));
      end else begin
        rnd <= rnd + 4'd1;
        c_q <= rot(c_q, dir_cur, !one_step);
        d_q <= rot(d_q, dir_cur, !one_step);
      end
    end
  end

endmodule
